// File: rtl/pwm_capture_if.sv
// Measurement bus of the PWM capture block: the sampled pin in,
// period/high-time results and status strobes out.
interface pwm_capture_if #(
    parameter int CNT_W = 28
);
    logic             pwm_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             valid;
    logic             timeout;
    logic             lost;

    modport master (
        input  pwm_in,
        output period_out,
        output high_out,
        output valid,
        output timeout,
        output lost
    );

    modport slave (
        output pwm_in,
        input  period_out,
        input  high_out,
        input  valid,
        input  timeout,
        input  lost
    );
endinterface

// File: rtl/pwm_capture.sv
// Re-measures a PWM waveform: period and high time in clk_in cycles,
// with a per-measurement strobe and a loss-of-signal timeout.
module pwm_capture #(
    parameter int               CNT_W   = 28,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(1_000_000)
) (
    input  logic          clk_in,
    input  logic          rst,
    pwm_capture_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic sync1, sync2, prev;
    logic rise, fall;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] high_cap;
    logic [CNT_W-1:0] period_q, high_q;
    logic             valid_q, timeout_q, lost_q;

    logic expired;
    logic meas;
    logic lose;
    logic cap;

    // Two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= bus.pwm_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise    = sync2 & ~prev;
    assign fall    = ~sync2 & prev;
    assign expired = (cnt >= TIMEOUT);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Edges always win over an expired counter in the same cycle
    always_comb begin
        state_nxt = state;
        meas      = 1'b0;
        lose      = 1'b0;
        cap       = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_nxt = LOW;
                    cap       = 1'b1;
                end else if (expired) begin
                    state_nxt = IDLE;
                    lose      = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt = HIGH;
                    meas      = 1'b1;
                end else if (expired) begin
                    state_nxt = IDLE;
                    lose      = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (rise) begin
            cnt_nxt = CNT_ONE;
        end else if (state_nxt == IDLE) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            high_cap <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (cap) begin
                high_cap <= cnt;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            lost_q    <= 1'b1;
        end else begin
            valid_q   <= meas;
            timeout_q <= lose;
            if (meas) begin
                period_q <= cnt;
                high_q   <= high_cap;
            end
            if (lose) begin
                lost_q <= 1'b1;
            end else if (meas) begin
                lost_q <= 1'b0;
            end
        end
    end

    assign bus.period_out = period_q;
    assign bus.high_out   = high_q;
    assign bus.valid      = valid_q;
    assign bus.timeout    = timeout_q;
    assign bus.lost       = lost_q;

endmodule
